// File: rtl/wb_rr_bus_arbiter_pkg.sv
// Shared types and helpers for the round-robin Wishbone bus arbiter.
package wb_rr_bus_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Ceiling log2 for parameter sizing; returns 0 for values <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) result++;
    return result;
  endfunction

endpackage

// File: rtl/wb_rr_bus_arbiter_picker.sv
// Circular priority search: first set request at or after the pointer.
module wb_rr_picker
  import wb_rr_bus_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned ID_W  = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             found,
  output logic [N_REQ-1:0] onehot,
  output logic [ID_W-1:0]  index
);

  logic [ID_W-1:0] pos;

  always_comb begin
    found  = 1'b0;
    onehot = '0;
    index  = '0;
    pos    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos = ID_W'((32'(ptr) + k) % N_REQ);
      if (!found && req[pos]) begin
        found  = 1'b1;
        index  = pos;
        onehot = N_REQ'(1) << pos;
      end
    end
  end

endmodule

// File: rtl/wb_rr_bus_arbiter.sv
// Registered round-robin grant generator for masters sharing one Wishbone bus,
// with mandatory turnaround cycle and optional hold timeout.
module wb_rr_bus_arbiter
  import wb_rr_bus_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTERS        = 2,
  parameter int unsigned MAX_GRANT_CYCLES = 0,
  parameter int unsigned ID_WIDTH         = clog2(N_MASTERS),
  parameter int unsigned CNT_WIDTH        = (MAX_GRANT_CYCLES == 0) ? 1 : clog2(MAX_GRANT_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] cyc_i,
  output logic [N_MASTERS-1:0] gnt_o,
  output logic [ID_WIDTH-1:0]  gnt_id_o,
  output logic                 bus_busy_o,
  output logic                 timeout_o
);

  localparam bit                   TIMEOUT_EN = (MAX_GRANT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT  = CNT_WIDTH'(MAX_GRANT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [ID_WIDTH-1:0]  LAST_ID    = ID_WIDTH'(N_MASTERS - 1);

  arb_state_e           state_q, state_d;
  logic [ID_WIDTH-1:0]  ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [N_MASTERS-1:0] revoked_q, revoked_d;
  logic [N_MASTERS-1:0] gnt_d;
  logic [ID_WIDTH-1:0]  gnt_id_d;
  logic                 busy_d;
  logic                 timeout_d;

  logic                 pick_found;
  logic [N_MASTERS-1:0] pick_onehot;
  logic [ID_WIDTH-1:0]  pick_idx;
  logic [ID_WIDTH-1:0]  next_ptr;

  wb_rr_picker #(
    .N_REQ (N_MASTERS),
    .ID_W  (ID_WIDTH)
  ) u_picker (
    .req    (cyc_i & ~revoked_q),
    .ptr    (ptr_q),
    .found  (pick_found),
    .onehot (pick_onehot),
    .index  (pick_idx)
  );

  assign next_ptr = (gnt_id_o == LAST_ID) ? '0 : gnt_id_o + ID_WIDTH'(1);

  // State, pointer, counter, revoke mask and all outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      revoked_q  <= '0;
      gnt_o      <= '0;
      gnt_id_o   <= '0;
      bus_busy_o <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      revoked_q  <= revoked_d;
      gnt_o      <= gnt_d;
      gnt_id_o   <= gnt_id_d;
      bus_busy_o <= busy_d;
      timeout_o  <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    revoked_d = revoked_q & cyc_i;
    gnt_d     = gnt_o;
    gnt_id_d  = gnt_id_o;
    busy_d    = bus_busy_o;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d  = GRANT;
          gnt_d    = pick_onehot;
          gnt_id_d = pick_idx;
          busy_d   = 1'b1;
          cnt_d    = CNT_WIDTH'(1);
        end
      end
      GRANT: begin
        // A release on the limit cycle wins over the timeout
        if (!cyc_i[gnt_id_o]) begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = next_ptr;
        end else if (TIMEOUT_EN && cnt_q == CNT_LIMIT) begin
          state_d             = IDLE;
          gnt_d               = '0;
          busy_d              = 1'b0;
          ptr_d               = next_ptr;
          timeout_d           = 1'b1;
          revoked_d[gnt_id_o] = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
